// File: rtl/fpu_trivial_stack.sv
// 8087 trivial-op register stack (constants, FABS/FCHS, FNOP/FWAIT, FLD/FSTP m80); FXCH ST(i) when FPU_TRIVIAL_FXCH_EN is defined.
// Accept -> execute next cycle -> response held until rsp_ready; cmd_ready only while idle.
module fpu_trivial_stack #(
    parameter int DEPTH = 8,
    parameter int TW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_opcode,
    input  logic [7:0]         cmd_modrm,
    input  logic [79:0]        cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [79:0]        rsp_data,
    output logic               rsp_error,
    output logic [TW-1:0]      top,
    output logic [2*DEPTH-1:0] tag_word,
    output logic               stack_fault,
    input  logic               fault_clr
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    localparam logic [79:0] C_ONE   = 80'h3FFF8000000000000000;
    localparam logic [79:0] C_L2T   = 80'h4000D49A784BCD1B8AFE;
    localparam logic [79:0] C_L2E   = 80'h3FFFB8AA3B295C17F0BC;
    localparam logic [79:0] C_PI    = 80'h4000C90FDAA22168C235;
    localparam logic [79:0] C_LG2   = 80'h3FFD9A209A84FBCFF799;
    localparam logic [79:0] C_LN2   = 80'h3FFEB17217F7D1CF79AC;
    localparam logic [79:0] C_INDEF = 80'hFFFFC000000000000000;

    state_t        state_q, state_d;
    logic [7:0]    op_q, op_d, modrm_q, modrm_d;
    logic [79:0]   data_q, data_d;
    logic [79:0]   regs_q [DEPTH];
    logic [79:0]   regs_d [DEPTH];
    logic [1:0]    tag_q  [DEPTH];
    logic [1:0]    tag_d  [DEPTH];
    logic [TW-1:0] top_q, top_d, top_m1;
    logic [79:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          fault_q, fault_d, fault_set;
    logic          do_push, do_stp, do_chs, do_abs, invalid;
    logic [79:0]   push_val;
`ifdef FPU_TRIVIAL_FXCH_EN
    logic          do_xch;
    logic [TW-1:0] xch_idx;
`endif

    function automatic logic [1:0] tag_of(input logic [78:0] mag);
        return (mag == '0) ? 2'b01 : 2'b00;
    endfunction

    assign top_m1 = top_q - TW'(1);

    always_comb begin
        do_push  = 1'b0;
        do_stp   = 1'b0;
        do_chs   = 1'b0;
        do_abs   = 1'b0;
        invalid  = 1'b0;
        push_val = '0;
`ifdef FPU_TRIVIAL_FXCH_EN
        do_xch   = 1'b0;
        xch_idx  = top_q + TW'(modrm_q[2:0]);
`endif
        case (op_q)
            8'hD9: begin
                case (modrm_q)
                    8'hE8: begin do_push = 1'b1; push_val = C_ONE; end
                    8'hE9: begin do_push = 1'b1; push_val = C_L2T; end
                    8'hEA: begin do_push = 1'b1; push_val = C_L2E; end
                    8'hEB: begin do_push = 1'b1; push_val = C_PI;  end
                    8'hEC: begin do_push = 1'b1; push_val = C_LG2; end
                    8'hED: begin do_push = 1'b1; push_val = C_LN2; end
                    8'hEE: begin do_push = 1'b1; push_val = '0;    end
                    8'hE0: do_chs = 1'b1;
                    8'hE1: do_abs = 1'b1;
                    8'hD0: begin end
`ifdef FPU_TRIVIAL_FXCH_EN
                    8'hC8, 8'hC9, 8'hCA, 8'hCB,
                    8'hCC, 8'hCD, 8'hCE, 8'hCF: do_xch = 1'b1;
`endif
                    default: invalid = 1'b1;
                endcase
            end
            8'h9B: begin end
            8'hDB: begin
                if (modrm_q[7:6] != 2'b11 && modrm_q[5:3] == 3'd5) begin
                    do_push  = 1'b1;
                    push_val = data_q;
                end else if (modrm_q[7:6] != 2'b11 && modrm_q[5:3] == 3'd7) begin
                    do_stp = 1'b1;
                end else begin
                    invalid = 1'b1;
                end
            end
            default: invalid = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        modrm_d    = modrm_q;
        data_d     = data_q;
        regs_d     = regs_q;
        tag_d      = tag_q;
        top_d      = top_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        fault_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_opcode;
                    modrm_d = cmd_modrm;
                    data_d  = cmd_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d    = S_RESP;
                rsp_data_d = '0;
                rsp_err_d  = invalid;
                if (do_push) begin
                    if (tag_q[top_m1] != 2'b11) begin
                        rsp_err_d = 1'b1;
                        fault_set = 1'b1;
                    end else begin
                        regs_d[top_m1] = push_val;
                        tag_d[top_m1]  = tag_of(push_val[78:0]);
                        top_d          = top_m1;
                    end
                end
                if (do_stp) begin
                    if (tag_q[top_q] == 2'b11) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = C_INDEF;
                        fault_set  = 1'b1;
                    end else begin
                        rsp_data_d    = regs_q[top_q];
                        tag_d[top_q]  = 2'b11;
                        top_d         = top_q + TW'(1);
                    end
                end
                if (do_chs || do_abs) begin
                    if (tag_q[top_q] == 2'b11) begin
                        rsp_err_d = 1'b1;
                        fault_set = 1'b1;
                    end else begin
                        regs_d[top_q][79] = do_chs ? ~regs_q[top_q][79] : 1'b0;
                    end
                end
`ifdef FPU_TRIVIAL_FXCH_EN
                if (do_xch) begin
                    if (tag_q[top_q] == 2'b11 || tag_q[xch_idx] == 2'b11) begin
                        rsp_err_d = 1'b1;
                        fault_set = 1'b1;
                    end else begin
                        regs_d[top_q]   = regs_q[xch_idx];
                        regs_d[xch_idx] = regs_q[top_q];
                        tag_d[top_q]    = tag_q[xch_idx];
                        tag_d[xch_idx]  = tag_q[top_q];
                    end
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // a new fault in the same cycle as fault_clr wins
        fault_d = (fault_clr ? 1'b0 : fault_q) | fault_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            modrm_q    <= '0;
            data_q     <= '0;
            top_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            fault_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= 2'b11;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            modrm_q    <= modrm_d;
            data_q     <= data_d;
            top_q      <= top_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            fault_q    <= fault_d;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
        end
    end

    // register contents carry no reset; the tags say what is live
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_tag
        assign tag_word[2*g +: 2] = tag_q[g];
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_err_q;
    assign top         = top_q;
    assign stack_fault = fault_q;

endmodule

// File: tb/tb_fpu_trivial_stack.sv
// Directed bench for fpu_trivial_stack with hand-computed expectations (DEPTH = 8).
module tb_fpu_trivial_stack;
    localparam int DEPTH = 8;
    localparam int TW    = 3;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [7:0]         cmd_opcode;
    logic [7:0]         cmd_modrm;
    logic [79:0]        cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [79:0]        rsp_data;
    logic               rsp_error;
    logic [TW-1:0]      top;
    logic [2*DEPTH-1:0] tag_word;
    logic               stack_fault;
    logic               fault_clr;

    int checks = 0;
    int errors = 0;
    logic [79:0] rd;
    logic        re;

    fpu_trivial_stack #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_modrm(cmd_modrm), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_error(rsp_error),
        .top(top), .tag_word(tag_word),
        .stack_fault(stack_fault), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Issues one command with rsp_ready high, returns the response; exits 1ns after the handshake edge.
    task automatic do_cmd(input logic [7:0] op, input logic [7:0] mr, input logic [79:0] d,
                          output logic [79:0] r_dat, output logic r_err);
        int n;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        cmd_valid = 1'b1; cmd_opcode = op; cmd_modrm = mr; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: op %h %h got rsp_valid=0 required 1", op, mr);
        end
        r_dat = rsp_data;
        r_err = rsp_error;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_modrm = '0; cmd_data = '0;
        rsp_ready = 1'b1; fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        checks++; if (rsp_data !== 80'h0) begin errors++; $display("FAIL reset_rsp_data: got %h required 0", rsp_data); end
        checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error: got %b required 0", rsp_error); end
        checks++; if (top !== 3'd0) begin errors++; $display("FAIL reset_top: got %0d required 0", top); end
        checks++; if (tag_word !== 16'hFFFF) begin errors++; $display("FAIL reset_tags: got %h required ffff", tag_word); end
        checks++; if (stack_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b required 0", stack_fault); end
    endtask

    task automatic test_fld1_fstp();
        do_cmd(8'hD9, 8'hE8, '0, rd, re);
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL fld1_err: got %b required 0", re); end
        checks++; if (top !== 3'd7) begin errors++; $display("FAIL fld1_top: got %0d required 7", top); end
        checks++; if (tag_word !== 16'h3FFF) begin errors++; $display("FAIL fld1_tags: got %h required 3fff", tag_word); end
        do_cmd(8'hDB, 8'h38, '0, rd, re);
        checks++; if (rd !== 80'h3FFF8000000000000000) begin errors++; $display("FAIL fstp_one: got %h required 3fff8000000000000000", rd); end
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL fstp_one_err: got %b required 0", re); end
        checks++; if (top !== 3'd0) begin errors++; $display("FAIL fstp_one_top: got %0d required 0", top); end
        checks++; if (tag_word !== 16'hFFFF) begin errors++; $display("FAIL fstp_one_tags: got %h required ffff", tag_word); end
    endtask

    task automatic test_constants();
        logic [79:0] exp_v [3];
        exp_v[0] = 80'h0;
        exp_v[1] = 80'h3FFEB17217F7D1CF79AC;
        exp_v[2] = 80'h4000C90FDAA22168C235;
        do_cmd(8'hD9, 8'hEB, '0, rd, re);
        do_cmd(8'hD9, 8'hED, '0, rd, re);
        do_cmd(8'hD9, 8'hEE, '0, rd, re);
        checks++; if (top !== 3'd5) begin errors++; $display("FAIL const_top: got %0d required 5", top); end
        checks++; if (tag_word !== 16'h07FF) begin errors++; $display("FAIL const_tags: got %h required 07ff", tag_word); end
        for (int i = 0; i < 3; i++) begin
            do_cmd(8'hDB, 8'h38, '0, rd, re);
            checks++; if (rd !== exp_v[i] || re !== 1'b0) begin
                errors++; $display("FAIL const_pop%0d: got %h err %b required %h err 0", i, rd, re, exp_v[i]);
            end
        end
        checks++; if (top !== 3'd0) begin errors++; $display("FAIL const_final_top: got %0d required 0", top); end
    endtask

    task automatic test_abs_chs();
        do_cmd(8'hDB, 8'h28, 80'hC000A000000000000000, rd, re);
        do_cmd(8'hD9, 8'hE1, '0, rd, re);
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL fabs_err: got %b required 0", re); end
        do_cmd(8'hDB, 8'h38, '0, rd, re);
        checks++; if (rd !== 80'h4000A000000000000000) begin errors++; $display("FAIL fabs_val: got %h required 4000a000000000000000", rd); end
        do_cmd(8'hDB, 8'h28, 80'h4000C000000000000000, rd, re);
        do_cmd(8'hD9, 8'hE0, '0, rd, re);
        do_cmd(8'hDB, 8'h38, '0, rd, re);
        checks++; if (rd !== 80'hC000C000000000000000) begin errors++; $display("FAIL fchs_val: got %h required c000c000000000000000", rd); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) do_cmd(8'hD9, 8'hE8, '0, rd, re);
        checks++; if (top !== 3'd0 || tag_word !== 16'h0000) begin errors++; $display("FAIL full_state: got top %0d tags %h required 0 0000", top, tag_word); end
        do_cmd(8'hD9, 8'hE8, '0, rd, re);
        checks++; if (re !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b required 1", re); end
        checks++; if (stack_fault !== 1'b1) begin errors++; $display("FAIL ovf_fault: got %b required 1", stack_fault); end
        checks++; if (top !== 3'd0) begin errors++; $display("FAIL ovf_top: got %0d required 0", top); end
        @(negedge clk); fault_clr = 1'b1;
        @(negedge clk); fault_clr = 1'b0;
        checks++; if (stack_fault !== 1'b0) begin errors++; $display("FAIL fault_clr: got %b required 0", stack_fault); end
        for (int i = 0; i < DEPTH; i++) begin
            do_cmd(8'hDB, 8'h38, '0, rd, re);
            checks++; if (rd !== 80'h3FFF8000000000000000 || re !== 1'b0) begin
                errors++; $display("FAIL drain%0d: got %h err %b required 3fff8000000000000000 err 0", i, rd, re);
            end
        end
        checks++; if (tag_word !== 16'hFFFF) begin errors++; $display("FAIL drain_tags: got %h required ffff", tag_word); end
    endtask

    task automatic test_underflow_invalid();
        do_cmd(8'hDB, 8'h38, '0, rd, re);
        checks++; if (rd !== 80'hFFFFC000000000000000 || re !== 1'b1) begin
            errors++; $display("FAIL fstp_empty: got %h err %b required ffffc000000000000000 err 1", rd, re);
        end
        checks++; if (stack_fault !== 1'b1 || top !== 3'd0) begin errors++; $display("FAIL unf_state: got fault %b top %0d required 1 0", stack_fault, top); end
        @(negedge clk); fault_clr = 1'b1;
        @(negedge clk); fault_clr = 1'b0;
        do_cmd(8'hD9, 8'hFF, '0, rd, re);
        checks++; if (re !== 1'b1) begin errors++; $display("FAIL invalid_err: got %b required 1", re); end
        checks++; if (stack_fault !== 1'b0) begin errors++; $display("FAIL invalid_fault: got %b required 0", stack_fault); end
        do_cmd(8'hD9, 8'hE0, '0, rd, re);
        checks++; if (re !== 1'b1 || stack_fault !== 1'b1) begin errors++; $display("FAIL fchs_empty: got err %b fault %b required 1 1", re, stack_fault); end
        do_cmd(8'h9B, 8'h00, '0, rd, re);
        checks++; if (re !== 1'b0 || rd !== 80'h0 || top !== 3'd0) begin errors++; $display("FAIL fwait: got err %b data %h top %0d required 0 0 0", re, rd, top); end
        do_cmd(8'hDB, 8'hE8, '0, rd, re);
        checks++; if (re !== 1'b1 || tag_word !== 16'hFFFF) begin errors++; $display("FAIL db_reg_form: got err %b tags %h required 1 ffff", re, tag_word); end
    endtask

    task automatic test_latency();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 8'hD9; cmd_modrm = 8'hE8; cmd_data = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL lat_exec: got rsp_valid %b cmd_ready %b required 0 0", rsp_valid, cmd_ready); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL lat_resp: got %b required 1", rsp_valid); end
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1 || top !== 3'd7) begin errors++; $display("FAIL lat_idle: got cmd_ready %b top %0d required 1 7", cmd_ready, top); end
        do_cmd(8'hDB, 8'h38, '0, rd, re);
    endtask

    task automatic test_backpressure_reset();
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 8'hD9; cmd_modrm = 8'hEB; cmd_data = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1; cmd_modrm = 8'hE8;
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_error !== 1'b0) begin
                errors++; $display("FAIL hold%0d: got rsp_valid %b cmd_ready %b err %b required 1 0 0", i, rsp_valid, cmd_ready, rsp_error);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1 || top !== 3'd7 || tag_word !== 16'h3FFF) begin
            errors++; $display("FAIL hold_release: got cmd_ready %b top %0d tags %h required 1 7 3fff", cmd_ready, top, tag_word);
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 8'hD9; cmd_modrm = 8'hE8;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || top !== 3'd0 || tag_word !== 16'hFFFF || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset: got rsp_valid %b top %0d tags %h cmd_ready %b required 0 0 ffff 1", rsp_valid, top, tag_word, cmd_ready);
        end
        @(negedge clk); reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fld1_fstp();
        test_constants();
        test_abs_chs();
        test_overflow();
        test_underflow_invalid();
        test_latency();
        test_backpressure_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
